// File: rtl/pwm_gen.sv
// pwm_gen: motor PWM generator fed by the PID controller's ratio request stream.
// Latency: pwm_out is registered one clock behind pwm_cnt; a new ratio takes effect at the next period boundary.
// Backpressure: none. The request stream is sampled every clock, and the last request before a boundary wins.
//
// Ports:
//   clock, reset          main clock, synchronous active-high reset
//   pwm_enable            level, 1 = run, 0 = force idle
//   pwm_update/pwm_ratio  ratio request (valid level + 8-bit high time out of 255)
//   pwm_direction         requested motor direction
//   pwm_done              one-clock pulse when a new ratio becomes active
//   pwm_out, pwm_dir_out  registered H-bridge drive
//   active_ratio          ratio currently applied (debug)
//   in_deadtime           high while the bridge is held low for a direction reversal
module pwm_gen #(
   parameter int CLK_DIV          = 4,
   parameter int DEADTIME_PERIODS = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pwm_enable,
   input  logic       pwm_update,
   input  logic [7:0] pwm_ratio,
   input  logic       pwm_direction,
   output logic       pwm_done,
   output logic       pwm_out,
   output logic       pwm_dir_out,
   output logic [7:0] active_ratio,
   output logic       in_deadtime
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DT_W  = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DEADTIME_PERIODS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t            state;
   logic [PRE_W-1:0]  pre_cnt;
   logic [7:0]        pwm_cnt;
   logic [DT_W-1:0]   dt_cnt;
   logic [7:0]        pending;
   logic              pend_valid;
   logic              tick;
   logic              boundary;

   assign tick     = (pre_cnt == PRE_LAST);
   // pwm_cnt runs 0..254, so a period is 255 ticks and ratio 255 is constant high.
   assign boundary = tick && (pwm_cnt == 8'd254);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         pre_cnt      <= '0;
         pwm_cnt      <= '0;
         dt_cnt       <= '0;
         pending      <= '0;
         pend_valid   <= 1'b0;
         pwm_done     <= 1'b0;
         pwm_out      <= 1'b0;
         pwm_dir_out  <= 1'b0;
         active_ratio <= '0;
         in_deadtime  <= 1'b0;
      end else begin
         pwm_done <= 1'b0;
         if (!pwm_enable) begin
            // pwm_dir_out deliberately holds so the bridge keeps its last direction.
            state        <= S_IDLE;
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            dt_cnt       <= '0;
            pend_valid   <= 1'b0;
            pwm_out      <= 1'b0;
            active_ratio <= '0;
            in_deadtime  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  pre_cnt     <= '0;
                  pwm_cnt     <= '0;
                  dt_cnt      <= '0;
                  pend_valid  <= 1'b0;
                  pwm_out     <= 1'b0;
                  state       <= S_RUN;
                  pwm_dir_out <= pwm_direction;
                  if (pwm_update) begin
                     active_ratio <= pwm_ratio;
                     pwm_done     <= 1'b1;
                  end
               end

               S_RUN: begin
                  if (pwm_update) begin
                     pending    <= pwm_ratio;
                     pend_valid <= 1'b1;
                  end
                  if (pwm_direction != pwm_dir_out) begin
                     // Reversal wins over a same-cycle ratio transfer; the ratio stays pending.
                     state       <= S_DEAD;
                     in_deadtime <= 1'b1;
                     pwm_out     <= 1'b0;
                     pre_cnt     <= '0;
                     pwm_cnt     <= '0;
                     dt_cnt      <= '0;
                  end else begin
                     pwm_out <= (pwm_cnt < active_ratio);
                     if (tick) begin
                        pre_cnt <= '0;
                        pwm_cnt <= boundary ? 8'd0 : pwm_cnt + 8'd1;
                     end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                     end
                     // A live request at the boundary bypasses the pending register.
                     if (boundary && (pwm_update || pend_valid)) begin
                        active_ratio <= pwm_update ? pwm_ratio : pending;
                        pend_valid   <= 1'b0;
                        pwm_done     <= 1'b1;
                     end
                  end
               end

               S_DEAD: begin
                  if (pwm_update) begin
                     pending    <= pwm_ratio;
                     pend_valid <= 1'b1;
                  end
                  pwm_out <= 1'b0;
                  if (tick) begin
                     pre_cnt <= '0;
                     pwm_cnt <= boundary ? 8'd0 : pwm_cnt + 8'd1;
                  end else begin
                     pre_cnt <= pre_cnt + 1'b1;
                  end
                  if (boundary) begin
                     if (dt_cnt == DT_LAST) begin
                        // Direction is resampled only here, so a toggle-back still serves the full deadtime.
                        state       <= S_RUN;
                        in_deadtime <= 1'b0;
                        dt_cnt      <= '0;
                        pwm_dir_out <= pwm_direction;
                        if (pwm_update || pend_valid) begin
                           active_ratio <= pwm_update ? pwm_ratio : pending;
                           pend_valid   <= 1'b0;
                           pwm_done     <= 1'b1;
                        end
                     end else begin
                        dt_cnt <= dt_cnt + 1'b1;
                     end
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed bench for pwm_gen with CLK_DIV=2, DEADTIME_PERIODS=2 (510-clock period).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is driven between edges.
module tb_pwm_gen;

   logic       clock = 1'b0;
   logic       reset;
   logic       pwm_enable;
   logic       pwm_update;
   logic [7:0] pwm_ratio;
   logic       pwm_direction;
   logic       pwm_done;
   logic       pwm_out;
   logic       pwm_dir_out;
   logic [7:0] active_ratio;
   logic       in_deadtime;

   int checks = 0;
   int errors = 0;

   pwm_gen #(.CLK_DIV(2), .DEADTIME_PERIODS(2)) dut (
      .clock         (clock),
      .reset         (reset),
      .pwm_enable    (pwm_enable),
      .pwm_update    (pwm_update),
      .pwm_ratio     (pwm_ratio),
      .pwm_direction (pwm_direction),
      .pwm_done      (pwm_done),
      .pwm_out       (pwm_out),
      .pwm_dir_out   (pwm_dir_out),
      .active_ratio  (active_ratio),
      .in_deadtime   (in_deadtime)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps n cycles and accumulates pwm_out, pwm_done and in_deadtime samples.
   task automatic run_count(input int n, output int hi, output int dn, output int dt);
      hi = 0; dn = 0; dt = 0;
      for (int i = 0; i < n; i++) begin
         step();
         hi += int'(pwm_out);
         dn += int'(pwm_done);
         dt += int'(in_deadtime);
      end
   endtask

   // Length of the pwm_out run at 'level' starting at the current sample (bounded).
   task automatic run_len(input logic level, output int len);
      len = 0;
      while (pwm_out == level && len < 2000) begin
         step();
         len++;
      end
   endtask

   // Enable with a ratio request; leaves the bench one sample after entering RUN (phase p=0).
   task automatic start(input logic [7:0] r);
      pwm_enable = 1'b1;
      pwm_update = 1'b1;
      pwm_ratio  = r;
      step();
      check("start_done", int'(pwm_done), 1);
      check("start_ratio", int'(active_ratio), int'(r));
      pwm_update = 1'b0;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      pwm_enable    = 1'b0;
      pwm_update    = 1'b0;
      pwm_ratio     = 8'd0;
      pwm_direction = 1'b0;
      steps(2);
      reset = 1'b0;
   endtask

   function automatic int sched(input int p);
      if (p < 1020)      return (p * 3) & 255;
      else if (p < 2040) return 0;
      else               return 255;
   endfunction

   int len, hi, dn, dt, hi_a, hi_b;

   initial begin
      // Reset state
      do_reset();
      check("rst_out", int'(pwm_out), 0);
      check("rst_dir", int'(pwm_dir_out), 0);
      check("rst_done", int'(pwm_done), 0);
      check("rst_ratio", int'(active_ratio), 0);
      check("rst_dt", int'(in_deadtime), 0);

      // Ratio 128: 256 high, 254 low, repeating
      start(8'd128);
      step();
      check("r128_done_clr", int'(pwm_done), 0);
      run_len(1'b1, len); check("r128_high", len, 256);
      run_len(1'b0, len); check("r128_low", len, 254);
      run_len(1'b1, len); check("r128_high2", len, 256);

      // Mid-period update at pwm_cnt=100 waits for the boundary
      do_reset();
      start(8'd64);
      steps(200);
      pwm_update = 1'b1; pwm_ratio = 8'd200;
      step();
      pwm_update = 1'b0;
      check("mid_hold", int'(active_ratio), 64);
      steps(308);
      check("pre_bnd_ratio", int'(active_ratio), 64);
      check("pre_bnd_done", int'(pwm_done), 0);
      step();
      check("bnd_ratio", int'(active_ratio), 200);
      check("bnd_done", int'(pwm_done), 1);
      check("bnd_out", int'(pwm_out), 0);
      step();
      check("bnd_done_clr", int'(pwm_done), 0);
      run_len(1'b1, len); check("r200_high", len, 400);

      // pwm_update held high, ratio changing every clock
      do_reset();
      start(8'd10);
      pwm_update = 1'b1;
      dn = 0; hi_a = 0; hi_b = 0;
      for (int p = 0; p < 3060; p++) begin
         pwm_ratio = 8'(sched(p));
         step();
         if (pwm_done) begin
            dn++;
            check("hold_done_phase", (p + 1) % 510, 0);
            check("hold_done_ratio", int'(active_ratio), sched(p));
         end
         if (p + 1 >= 1531 && p + 1 <= 2040) hi_a += int'(pwm_out);
         if (p + 1 >= 2551 && p + 1 <= 3060) hi_b += int'(pwm_out);
      end
      pwm_update = 1'b0;
      check("hold_done_cnt", dn, 6);
      check("ratio0_high", hi_a, 0);
      check("ratio255_high", hi_b, 510);

      // Direction reversal with same-cycle ratio request
      do_reset();
      start(8'd64);
      steps(100);
      pwm_direction = 1'b1; pwm_update = 1'b1; pwm_ratio = 8'd150;
      step();
      pwm_update = 1'b0;
      check("dt_enter", int'(in_deadtime), 1);
      check("dt_out", int'(pwm_out), 0);
      check("dt_dir_hold", int'(pwm_dir_out), 0);
      check("dt_ratio_hold", int'(active_ratio), 64);
      run_count(1019, hi, dn, dt);
      check("dt_high", hi, 0);
      check("dt_done", dn, 0);
      check("dt_len", dt, 1019);
      check("dt_dir_late", int'(pwm_dir_out), 0);
      step();
      check("dt_exit", int'(in_deadtime), 0);
      check("dt_exit_dir", int'(pwm_dir_out), 1);
      check("dt_exit_ratio", int'(active_ratio), 150);
      check("dt_exit_done", int'(pwm_done), 1);
      step();
      check("dt_resume_out", int'(pwm_out), 1);

      // Drop enable mid-high, re-enable without a ratio
      steps(10);
      check("hi_before_drop", int'(pwm_out), 1);
      pwm_enable = 1'b0;
      step();
      check("drop_out", int'(pwm_out), 0);
      check("drop_ratio", int'(active_ratio), 0);
      check("drop_dir_hold", int'(pwm_dir_out), 1);
      pwm_enable = 1'b1;
      step();
      check("reen_ratio", int'(active_ratio), 0);
      check("reen_done", int'(pwm_done), 0);
      step();
      pwm_update = 1'b1; pwm_ratio = 8'd50;
      step();
      pwm_update = 1'b0;
      run_count(507, hi, dn, dt);
      check("reen_low", hi, 0);
      check("reen_nodone", dn, 0);
      step();
      check("reen_apply_done", int'(pwm_done), 1);
      check("reen_apply_ratio", int'(active_ratio), 50);
      step();
      run_len(1'b1, len); check("r50_high", len, 100);

      // Reset during deadtime, then clean restart
      pwm_direction = 1'b0;
      steps(51);
      check("dt2_active", int'(in_deadtime), 1);
      reset = 1'b1;
      step();
      check("mrst_out", int'(pwm_out), 0);
      check("mrst_dir", int'(pwm_dir_out), 0);
      check("mrst_done", int'(pwm_done), 0);
      check("mrst_ratio", int'(active_ratio), 0);
      check("mrst_dt", int'(in_deadtime), 0);
      reset = 1'b0;
      start(8'd128);
      step();
      run_len(1'b1, len); check("restart_high", len, 256);
      check("restart_dt", int'(in_deadtime), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
